// File: rtl/axi_lsu_nslave_bridge.sv
// AXI load/store-unit bridge: one master port fanned out to NS slave ports.
// Slave 0 is the default target and returns its own IDs; slaves 1..NS-1 are
// decoded by BASE/MASK windows and have their request IDs held in per-slave
// FIFOs. Write data is routed by a FIFO of AW targets, with a same-cycle bypass.
module axi_lsu_nslave_bridge #(
    parameter int unsigned        NS          = 2,
    parameter int unsigned        M_ID_WIDTH  = 8,
    parameter int unsigned        S0_ID_WIDTH = 8,
    parameter int unsigned        IDQ_DEPTH   = 4,
    parameter int unsigned        WQ_DEPTH    = 4,
    parameter logic [NS*32-1:0]   BASE        = '0,
    parameter logic [NS*32-1:0]   MASK        = '0
) (
    input  logic                   clk,
    input  logic                   reset_l,
    // master read address / data
    input  logic                   m_arvalid,
    input  logic [M_ID_WIDTH-1:0]  m_arid,
    input  logic [31:0]            m_araddr,
    output logic                   m_arready,
    output logic                   m_rvalid,
    input  logic                   m_rready,
    output logic [63:0]            m_rdata,
    output logic [M_ID_WIDTH-1:0]  m_rid,
    output logic [1:0]             m_rresp,
    output logic                   m_rlast,
    // master write address / data / response
    input  logic                   m_awvalid,
    input  logic [M_ID_WIDTH-1:0]  m_awid,
    input  logic [31:0]            m_awaddr,
    output logic                   m_awready,
    input  logic                   m_wvalid,
    output logic                   m_wready,
    output logic                   m_bvalid,
    input  logic                   m_bready,
    output logic [M_ID_WIDTH-1:0]  m_bid,
    output logic [1:0]             m_bresp,
    // slave request handshakes
    output logic [NS-1:0]          s_arvalid,
    input  logic [NS-1:0]          s_arready,
    output logic [NS-1:0]          s_awvalid,
    input  logic [NS-1:0]          s_awready,
    output logic [NS-1:0]          s_wvalid,
    input  logic [NS-1:0]          s_wready,
    // slave read data
    input  logic [NS-1:0]          s_rvalid,
    output logic [NS-1:0]          s_rready,
    input  logic [NS*64-1:0]       s_rdata,
    input  logic [NS*2-1:0]        s_rresp,
    input  logic [NS-1:0]          s_rlast,
    input  logic [S0_ID_WIDTH-1:0] s0_rid,
    // slave write response
    input  logic [NS-1:0]          s_bvalid,
    output logic [NS-1:0]          s_bready,
    input  logic [NS*2-1:0]        s_bresp,
    input  logic [S0_ID_WIDTH-1:0] s0_bid
);

    localparam int unsigned SW  = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned IPW = $clog2(IDQ_DEPTH);
    localparam int unsigned WPW = $clog2(WQ_DEPTH);
    localparam logic [IPW:0] IDQ_FULL = IDQ_DEPTH[IPW:0];
    localparam logic [WPW:0] WQ_FULL  = WQ_DEPTH[WPW:0];

    typedef logic [SW-1:0] sel_t;
    typedef enum logic {StIdle, StLock} r_state_e;

    // Lowest matching window wins; scanning downward lets the lower index overwrite.
    function automatic sel_t decode(input logic [31:0] addr);
        sel_t s = '0;
        for (int k = int'(NS) - 1; k >= 1; k--) begin
            if ((addr & MASK[k*32 +: 32]) == BASE[k*32 +: 32]) s = sel_t'(k);
        end
        return s;
    endfunction

    // First set bit at or above ptr, wrapping; returns ptr when nothing is set.
    function automatic sel_t rr_pick(input logic [NS-1:0] v, input sel_t ptr);
        sel_t g = ptr;
        logic found = 1'b0;
        int idx;
        for (int i = 0; i < int'(NS); i++) begin
            idx = (int'(ptr) + i) % int'(NS);
            if (!found && v[idx]) begin
                g = sel_t'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic sel_t next_idx(input sel_t i);
        return (int'(i) == int'(NS) - 1) ? '0 : i + 1'b1;
    endfunction

    sel_t ar_sel, aw_sel, w_route, r_gnt, b_gnt;
    sel_t r_rr_q, r_lock_q, b_rr_q;
    r_state_e r_state_q;
    logic ar_blk, aw_blk, ar_hs, aw_hs, w_hs, w_ok, r_hs, r_done, b_hs;
    logic [NS-1:0] arq_full, awq_full;
    logic [M_ID_WIDTH-1:0] arq_head [NS];
    logic [M_ID_WIDTH-1:0] awq_head [NS];

    sel_t wq_mem [WQ_DEPTH];
    logic [WPW-1:0] wq_wp_q, wq_rp_q;
    logic [WPW:0] wq_cnt_q;
    logic wq_empty, wq_full, wq_push, wq_pop;

    assign ar_sel = decode(m_araddr);
    assign aw_sel = decode(m_awaddr);
    // Slave 0 has no ID FIFO, so its full flag is tied low and the lookup suffices.
    assign ar_blk = arq_full[ar_sel];
    assign aw_blk = awq_full[aw_sel] | wq_full;
    assign ar_hs  = m_arvalid & m_arready;
    assign aw_hs  = m_awvalid & m_awready;
    assign w_hs   = m_wvalid & m_wready;
    assign r_hs   = m_rvalid & m_rready;
    assign r_done = r_hs & m_rlast;
    assign b_hs   = m_bvalid & m_bready;

    assign wq_empty = (wq_cnt_q == '0);
    assign wq_full  = (wq_cnt_q == WQ_FULL);
    // A bypassed W consumes the AW route directly, so that route is never queued.
    assign wq_push  = aw_hs & ~(wq_empty & w_hs);
    assign wq_pop   = w_hs & ~wq_empty;

    // Address channel steering to the decoded slave.
    always_comb begin
        s_arvalid         = '0;
        s_arvalid[ar_sel] = m_arvalid & ~ar_blk;
        m_arready         = s_arready[ar_sel] & ~ar_blk;
        s_awvalid         = '0;
        s_awvalid[aw_sel] = m_awvalid & ~aw_blk;
        m_awready         = s_awready[aw_sel] & ~aw_blk;
    end

    // W routing: queued route first, otherwise the AW being presented this cycle.
    always_comb begin
        w_route = wq_mem[wq_rp_q];
        w_ok    = 1'b1;
        if (wq_empty) begin
            w_route = aw_sel;
            w_ok    = m_awvalid & ~aw_blk;
        end
        s_wvalid          = '0;
        s_wvalid[w_route] = m_wvalid & w_ok;
        m_wready          = s_wready[w_route] & w_ok;
    end

    // W-route FIFO state.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wq_wp_q  <= '0;
            wq_rp_q  <= '0;
            wq_cnt_q <= '0;
        end else begin
            if (wq_push) begin
                wq_mem[wq_wp_q] <= aw_sel;
                wq_wp_q         <= wq_wp_q + 1'b1;
            end
            if (wq_pop) wq_rp_q <= wq_rp_q + 1'b1;
            if (wq_push && !wq_pop) wq_cnt_q <= wq_cnt_q + 1'b1;
            else if (wq_pop && !wq_push) wq_cnt_q <= wq_cnt_q - 1'b1;
        end
    end

    assign arq_full[0] = 1'b0;
    assign awq_full[0] = 1'b0;
    assign arq_head[0] = '0;
    assign awq_head[0] = '0;

    for (genvar k = 1; k < NS; k++) begin : g_idq
        logic [M_ID_WIDTH-1:0] ar_mem [IDQ_DEPTH];
        logic [M_ID_WIDTH-1:0] aw_mem [IDQ_DEPTH];
        logic [IPW-1:0] ar_wp_q, ar_rp_q, aw_wp_q, aw_rp_q;
        logic [IPW:0] ar_cnt_q, aw_cnt_q;
        logic ar_push, ar_pop, aw_push, aw_pop;

        assign ar_push     = ar_hs & (ar_sel == sel_t'(k));
        assign ar_pop      = r_done & (r_gnt == sel_t'(k)) & (ar_cnt_q != '0);
        assign aw_push     = aw_hs & (aw_sel == sel_t'(k));
        assign aw_pop      = b_hs & (b_gnt == sel_t'(k)) & (aw_cnt_q != '0);
        assign arq_full[k] = (ar_cnt_q == IDQ_FULL);
        assign awq_full[k] = (aw_cnt_q == IDQ_FULL);
        assign arq_head[k] = ar_mem[ar_rp_q];
        assign awq_head[k] = aw_mem[aw_rp_q];

        // Per-slave AR and AW ID FIFOs.
        always_ff @(posedge clk or negedge reset_l) begin
            if (!reset_l) begin
                ar_wp_q  <= '0;
                ar_rp_q  <= '0;
                ar_cnt_q <= '0;
                aw_wp_q  <= '0;
                aw_rp_q  <= '0;
                aw_cnt_q <= '0;
            end else begin
                if (ar_push) begin
                    ar_mem[ar_wp_q] <= m_arid;
                    ar_wp_q         <= ar_wp_q + 1'b1;
                end
                if (ar_pop) ar_rp_q <= ar_rp_q + 1'b1;
                if (ar_push && !ar_pop) ar_cnt_q <= ar_cnt_q + 1'b1;
                else if (ar_pop && !ar_push) ar_cnt_q <= ar_cnt_q - 1'b1;
                if (aw_push) begin
                    aw_mem[aw_wp_q] <= m_awid;
                    aw_wp_q         <= aw_wp_q + 1'b1;
                end
                if (aw_pop) aw_rp_q <= aw_rp_q + 1'b1;
                if (aw_push && !aw_pop) aw_cnt_q <= aw_cnt_q + 1'b1;
                else if (aw_pop && !aw_push) aw_cnt_q <= aw_cnt_q - 1'b1;
            end
        end
    end

    // R and B response muxing from the granted slave.
    always_comb begin
        r_gnt           = (r_state_q == StLock) ? r_lock_q : rr_pick(s_rvalid, r_rr_q);
        m_rvalid        = s_rvalid[r_gnt];
        s_rready        = '0;
        s_rready[r_gnt] = m_rready;
        m_rdata         = s_rdata[r_gnt*64 +: 64];
        m_rresp         = s_rresp[r_gnt*2 +: 2];
        m_rlast         = s_rlast[r_gnt];
        m_rid           = (r_gnt == '0) ? M_ID_WIDTH'(s0_rid) : arq_head[r_gnt];
        b_gnt           = rr_pick(s_bvalid, b_rr_q);
        m_bvalid        = s_bvalid[b_gnt];
        s_bready        = '0;
        s_bready[b_gnt] = m_bready;
        m_bresp         = s_bresp[b_gnt*2 +: 2];
        m_bid           = (b_gnt == '0) ? M_ID_WIDTH'(s0_bid) : awq_head[b_gnt];
    end

    // R arbiter FSM: lock onto a burst after its first beat, rotate priority on rlast.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state_q <= StIdle;
            r_lock_q  <= '0;
            r_rr_q    <= '0;
        end else begin
            unique case (r_state_q)
                StIdle: begin
                    if (r_hs && !m_rlast) begin
                        r_state_q <= StLock;
                        r_lock_q  <= r_gnt;
                    end
                end
                StLock: begin
                    if (r_done) r_state_q <= StIdle;
                end
                default: r_state_q <= StIdle;
            endcase
            if (r_done) r_rr_q <= next_idx(r_gnt);
        end
    end

    // B arbiter pointer: responses are single-beat, so rotate on every handshake.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) b_rr_q <= '0;
        else if (b_hs) b_rr_q <= next_idx(b_gnt);
    end

endmodule

// File: tb/tb_axi_lsu_nslave_bridge.sv
// Self-checking bench for axi_lsu_nslave_bridge with NS=3.
// Slave 1 window: 0xEE000000/0xFF000000; slave 2 window: 0xEE000000/0xFE000000
// (overlaps slave 1, so 0xEE... goes to slave 1 and 0xEF... to slave 2).
module tb_axi_lsu_nslave_bridge;

    logic clk = 1'b0;
    logic reset_l;
    logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [7:0] m_arid, m_rid, m_awid, m_bid, s0_rid, s0_bid;
    logic [31:0] m_araddr, m_awaddr;
    logic [63:0] m_rdata;
    logic [1:0] m_rresp, m_bresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [2:0] s_arvalid, s_arready, s_awvalid, s_awready, s_wvalid, s_wready;
    logic [2:0] s_rvalid, s_rready, s_rlast, s_bvalid, s_bready;
    logic [191:0] s_rdata;
    logic [5:0] s_rresp, s_bresp;

    int n_vec = 0;
    int n_bad = 0;

    axi_lsu_nslave_bridge #(
        .NS(3), .M_ID_WIDTH(8), .S0_ID_WIDTH(8), .IDQ_DEPTH(4), .WQ_DEPTH(4),
        .BASE({32'hEE000000, 32'hEE000000, 32'h0}),
        .MASK({32'hFE000000, 32'hFF000000, 32'h0})
    ) dut (
        .clk(clk), .reset_l(reset_l),
        .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_awvalid(s_awvalid),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s0_rid(s0_rid),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s0_bid(s0_bid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        arvalid;
        logic [31:0] addr;
        logic [2:0]  s_ardy;
        logic [2:0]  exp_sv;
        logic        exp_rdy;
    } ar_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_arvalid = 0; m_arid = 0; m_araddr = 0; m_rready = 0;
        m_awvalid = 0; m_awid = 0; m_awaddr = 0; m_wvalid = 0; m_bready = 0;
        s_arready = 0; s_awready = 0; s_wready = 0;
        s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rresp = 0; s0_rid = 0;
        s_bvalid = 0; s_bresp = 0; s0_bid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_l = 0;
        m_wvalid = 1;
        s_wready = 3'b111;
        #1;
        chk("rst_m_rvalid", m_rvalid, 0);
        chk("rst_m_bvalid", m_bvalid, 0);
        chk("rst_m_wready", m_wready, 0);
        tick();
        tick();
        m_wvalid = 0;
        s_wready = 0;
        reset_l = 1;
    endtask

    function automatic int dec(input logic [31:0] a);
        if ((a & 32'hFF000000) == 32'hEE000000) return 1;
        if ((a & 32'hFE000000) == 32'hEE000000) return 2;
        return 0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ar_vec_t tbl[7];
        logic [31:0] aw_addr[4];
        logic [2:0] w_exp[4];
        logic [2:0] r_exp[3];
        int q1[$];
        int q2[$];
        int rr;

        tbl[0] = '{1'b1, 32'hEE000010, 3'b010, 3'b010, 1'b1};
        tbl[1] = '{1'b1, 32'hEF000000, 3'b100, 3'b100, 1'b1};
        tbl[2] = '{1'b1, 32'h12345678, 3'b001, 3'b001, 1'b1};
        tbl[3] = '{1'b1, 32'hEEFFFFFF, 3'b101, 3'b010, 1'b0};
        tbl[4] = '{1'b1, 32'hEF800000, 3'b011, 3'b100, 1'b0};
        tbl[5] = '{1'b1, 32'h00000000, 3'b110, 3'b001, 1'b0};
        tbl[6] = '{1'b0, 32'hEE000000, 3'b010, 3'b000, 1'b1};

        idle_inputs();
        reset_l = 0;
        #3;
        do_reset();

        // Decode / AR steering table.
        foreach (tbl[i]) begin
            m_arvalid = tbl[i].arvalid;
            m_araddr  = tbl[i].addr;
            s_arready = tbl[i].s_ardy;
            m_arid    = 8'(i);
            #1;
            chk("ar_tbl_svalid", s_arvalid, tbl[i].exp_sv);
            chk("ar_tbl_ready", m_arready, tbl[i].exp_rdy);
            tick();
        end
        m_arvalid = 0;

        // Basic AR then R returning the stored ID.
        do_reset();
        m_arvalid = 1; m_araddr = 32'hEE000010; m_arid = 8'h5A; s_arready = 3'b010;
        #1;
        chk("ar1_svalid", s_arvalid, 3'b010);
        chk("ar1_ready", m_arready, 1);
        tick();
        m_arvalid = 0;
        s_rvalid = 3'b010; s_rlast = 3'b010; m_rready = 1;
        s_rdata = {64'h2, 64'hDEADBEEF01234567, 64'h0};
        s_rresp = 6'b00_10_00;
        #1;
        chk("r1_valid", m_rvalid, 1);
        chk("r1_rid", m_rid, 8'h5A);
        chk("r1_rready", s_rready, 3'b010);
        chk("r1_rdata", m_rdata, 64'hDEADBEEF01234567);
        chk("r1_rresp", m_rresp, 2'b10);
        tick();
        s_rvalid = 0;

        // AR ID FIFO fills, stalls, then frees one slot.
        do_reset();
        m_arvalid = 1; m_araddr = 32'hEE000020; s_arready = 3'b010;
        for (int i = 0; i < 4; i++) begin
            m_arid = 8'h10 + 8'(i);
            #1;
            chk("arfill_ready", m_arready, 1);
            tick();
        end
        m_arid = 8'h20;
        #1;
        chk("arfull_ready", m_arready, 0);
        chk("arfull_svalid", s_arvalid, 3'b000);
        s_rvalid = 3'b010; s_rlast = 3'b010; m_rready = 1;
        #1;
        chk("arfull_rid_head", m_rid, 8'h10);
        tick();
        s_rvalid = 0;
        #1;
        chk("arfree_ready", m_arready, 1);
        chk("arfree_svalid", s_arvalid, 3'b010);
        tick();
        m_arvalid = 0;

        // Four AWs with W held off, then W drains in order; then B round robin.
        do_reset();
        aw_addr[0] = 32'hEE000000; w_exp[0] = 3'b010;
        aw_addr[1] = 32'h00001000; w_exp[1] = 3'b001;
        aw_addr[2] = 32'hEE000004; w_exp[2] = 3'b010;
        aw_addr[3] = 32'hEF000000; w_exp[3] = 3'b100;
        s_awready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            m_awvalid = 1; m_awaddr = aw_addr[i]; m_awid = 8'h31 + 8'(i);
            #1;
            chk("aw_q_ready", m_awready, 1);
            tick();
        end
        m_awaddr = 32'h0; m_awid = 8'h40;
        #1;
        chk("aw_stall_ready", m_awready, 0);
        chk("aw_stall_svalid", s_awvalid, 3'b000);
        m_awvalid = 0; m_wvalid = 1; s_wready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("w_order_svalid", s_wvalid, w_exp[i]);
            chk("w_order_ready", m_wready, 1);
            tick();
        end
        #1;
        chk("w_empty_ready", m_wready, 0);
        chk("w_empty_svalid", s_wvalid, 3'b000);
        m_wvalid = 0;
        s_bvalid = 3'b111; m_bready = 1; s0_bid = 8'hC3; s_bresp = 6'b10_01_11;
        // Expected: grant 0, 1, 2, 0, 1 with IDs from slave 1's queue in AW order.
        for (int i = 0; i < 5; i++) begin
            logic [7:0] eid;
            logic [2:0] eready;
            logic [1:0] eresp;
            case (i % 3)
                0: begin eid = 8'hC3; eready = 3'b001; eresp = 2'b11; end
                1: begin eid = (i == 1) ? 8'h31 : 8'h33; eready = 3'b010; eresp = 2'b01; end
                default: begin eid = 8'h34; eready = 3'b100; eresp = 2'b10; end
            endcase
            #1;
            chk("b_rr_valid", m_bvalid, 1);
            chk("b_rr_bready", s_bready, eready);
            chk("b_rr_bid", m_bid, eid);
            chk("b_rr_bresp", m_bresp, eresp);
            tick();
        end
        s_bvalid = 0; m_bready = 0;

        // Same-cycle AW+W bypass with the route FIFO empty.
        m_awvalid = 1; m_awaddr = 32'hEF000010; m_awid = 8'h55; s_awready = 3'b111;
        m_wvalid = 1; s_wready = 3'b111;
        #1;
        chk("byp_awvalid", s_awvalid, 3'b100);
        chk("byp_wvalid", s_wvalid, 3'b100);
        chk("byp_wready", m_wready, 1);
        tick();
        m_awvalid = 0;
        #1;
        chk("byp_after_wready", m_wready, 0);
        chk("byp_after_wvalid", s_wvalid, 3'b000);
        m_wvalid = 0;

        // Slave 0 burst locks R; grants then rotate 1, 2, 0.
        do_reset();
        s_rvalid = 3'b111; m_rready = 1; s_rlast = 3'b110;
        s_rdata = {64'h2222, 64'h1111, 64'hAAAA};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                // Slave 0 pauses mid-burst; the lock must not hand R to anyone else.
                s_rvalid = 3'b110;
                #1;
                chk("lock_pause_valid", m_rvalid, 0);
                chk("lock_pause_rready", s_rready, 3'b001);
                tick();
                s_rvalid = 3'b111;
            end
            if (i == 3) s_rlast = 3'b111;
            #1;
            chk("lock_rready", s_rready, 3'b001);
            chk("lock_rdata", m_rdata, 64'hAAAA);
            chk("lock_rlast", m_rlast, (i == 3));
            tick();
        end
        r_exp[0] = 3'b010; r_exp[1] = 3'b100; r_exp[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rr_after_lock", s_rready, r_exp[i]);
            tick();
        end
        s_rvalid = 0;

        // Reset with IDs outstanding discards them.
        do_reset();
        m_arvalid = 1; m_araddr = 32'hEE000000; s_arready = 3'b010;
        for (int i = 1; i <= 3; i++) begin
            m_arid = 8'(i);
            tick();
        end
        do_reset();
        m_arvalid = 1; m_araddr = 32'hEE000000; s_arready = 3'b010; m_arid = 8'h77;
        #1;
        chk("post_rst_ready", m_arready, 1);
        tick();
        m_arvalid = 0;
        s_rvalid = 3'b010; s_rlast = 3'b010; m_rready = 1;
        #1;
        chk("post_rst_rid", m_rid, 8'h77);
        tick();
        s_rvalid = 0;

        // Randomized read traffic against a queue-based reference.
        do_reset();
        rr = 0;
        q1.delete();
        q2.delete();
        s_rlast = 3'b111;
        for (int c = 0; c < 400; c++) begin
            int sel, g;
            logic full, erdy;
            case ($urandom_range(0, 2))
                0: m_araddr = {8'hEE, 24'($urandom)};
                1: m_araddr = {8'hEF, 24'($urandom)};
                default: m_araddr = $urandom;
            endcase
            m_arvalid = 1'($urandom);
            m_arid = 8'($urandom);
            s_arready = 3'($urandom);
            s_rvalid[0] = 1'($urandom);
            s_rvalid[1] = 1'($urandom) && (q1.size() > 0);
            s_rvalid[2] = 1'($urandom) && (q2.size() > 0);
            m_rready = 1'($urandom);
            s0_rid = 8'($urandom);
            s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            sel = dec(m_araddr);
            full = (sel == 1 && q1.size() == 4) || (sel == 2 && q2.size() == 4);
            erdy = s_arready[sel] && !full;
            chk("rnd_arready", m_arready, erdy);
            chk("rnd_arvalid", s_arvalid, (m_arvalid && !full) ? (3'b001 << sel) : 3'b000);
            g = -1;
            for (int i = 0; i < 3; i++) begin
                int idx;
                idx = (rr + i) % 3;
                if (g < 0 && s_rvalid[idx]) g = idx;
            end
            chk("rnd_rvalid", m_rvalid, (g >= 0));
            if (g >= 0) begin
                logic [7:0] eid;
                eid = (g == 0) ? s0_rid : (g == 1) ? 8'(q1[0]) : 8'(q2[0]);
                chk("rnd_rid", m_rid, eid);
                chk("rnd_rready", s_rready, m_rready ? (3'b001 << g) : 3'b000);
                chk("rnd_rdata", m_rdata, s_rdata[g*64 +: 64]);
            end
            if (m_arvalid && erdy) begin
                if (sel == 1) q1.push_back(int'(m_arid));
                if (sel == 2) q2.push_back(int'(m_arid));
            end
            if (g >= 0 && m_rready) begin
                if (g == 1) void'(q1.pop_front());
                if (g == 2) void'(q2.pop_front());
                rr = (g + 1) % 3;
            end
            tick();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
